spi_protocol_monitor: RTL and testbench

Synthesisable, parametrised SPI-slave protocol monitor. It observes the SS_n/MOSI/MISO lines of the SPI-to-RAM slave, decodes every frame into command and payload, and captures read-back data. It flags length, ordering and MISO-idle violations and keeps a saturating error count. It sits passively beside the SPI wrapper in both simulation and silicon debug builds, and never drives the bus.

---
 rtl/spi_protocol_monitor_if.sv | 19 +
 rtl/spi_protocol_monitor.sv | 168 ++++++++++++++++
 tb/tb_spi_protocol_monitor.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_protocol_monitor_if.sv
// SPI bus bundle observed by the protocol monitor.
// Ports: SS_n, MOSI, MISO; master drives the lines, slave only samples.
interface spi_protocol_monitor_if;
    logic SS_n;
    logic MOSI;
    logic MISO;

    modport master (
        output SS_n,
        output MOSI,
        output MISO
    );

    modport slave (
        input SS_n,
        input MOSI,
        input MISO
    );
endinterface

// File: rtl/spi_protocol_monitor.sv
// Passive SPI-slave protocol monitor: decodes frames, captures read data,
// flags length/order/MISO-idle errors and keeps a saturating error count.
// Ports: clk, rst_n, bus (SS_n/MOSI/MISO, sampled only), frame_valid,
// frame_cmd, frame_data, rd_valid, rd_data, err_len, err_order, err_miso,
// err_count.
module spi_protocol_monitor #(
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_protocol_monitor_if.slave bus,
    output logic                 frame_valid,
    output logic [1:0]           frame_cmd,
    output logic [DATA_W-1:0]    frame_data,
    output logic                 rd_valid,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 err_len,
    output logic                 err_order,
    output logic                 err_miso,
    output logic [CNT_W-1:0]     err_count
);

    // One spare bit above the longest legal frame so saturation never
    // lands on a legal length.
    localparam int LEN_W = $clog2(2 * DATA_W + READ_LAT + 3) + 1;
    localparam int CW    = $clog2(DATA_W + 4);

    localparam logic [LEN_W-1:0] REQ_WR   = LEN_W'(2 + DATA_W);
    localparam logic [LEN_W-1:0] REQ_RD   = LEN_W'(2 + 2 * DATA_W + READ_LAT);
    localparam logic [CW-1:0]    BIT_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0]    GAP_LAST = CW'((READ_LAT > 0) ? READ_LAT - 1 : 0);

    typedef enum logic [2:0] {
        WAIT_HI,
        IDLE,
        CMD,
        PAYLOAD,
        GAP,
        RDATA,
        TAIL
    } state_t;

    state_t state_q, state_d;

    logic [LEN_W-1:0]  len_q;
    logic [CW-1:0]     cnt_q;
    logic [1:0]        cmd_q;
    logic [DATA_W-1:0] data_sr;
    logic [DATA_W-1:0] rd_sr;
    logic              rd_pending;

    logic ss;
    logic in_frame;
    logic frame_end;
    logic is_rd;
    logic len_ok;
    logic good;
    logic any_err;

    assign ss        = bus.SS_n;
    assign in_frame  = (state_q == CMD) || (state_q == PAYLOAD) ||
                       (state_q == GAP) || (state_q == RDATA) ||
                       (state_q == TAIL);
    assign frame_end = in_frame && ss;
    assign is_rd     = (cmd_q == 2'b11);
    assign len_ok    = is_rd ? (len_q == REQ_RD) : (len_q == REQ_WR);
    assign good      = frame_end && len_ok;
    assign any_err   = err_len || err_order || err_miso;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT_HI;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_HI: if (ss) state_d = IDLE;
            IDLE:    if (!ss) state_d = CMD;
            CMD:     state_d = ss ? IDLE : PAYLOAD;
            PAYLOAD: begin
                if (ss) state_d = IDLE;
                else if (cnt_q == BIT_LAST) begin
                    if (!is_rd)            state_d = TAIL;
                    else if (READ_LAT == 0) state_d = RDATA;
                    else                   state_d = GAP;
                end
            end
            GAP: begin
                if (ss) state_d = IDLE;
                else if (cnt_q == GAP_LAST) state_d = RDATA;
            end
            RDATA: begin
                if (ss) state_d = IDLE;
                else if (cnt_q == BIT_LAST) state_d = TAIL;
            end
            TAIL:    if (ss) state_d = IDLE;
            default: state_d = WAIT_HI;
        endcase
    end

    // Frame bookkeeping: length, bit counter, command and shift registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            cnt_q   <= '0;
            cmd_q   <= 2'b00;
            data_sr <= '0;
            rd_sr   <= '0;
        end else if (!ss) begin
            if (state_q == IDLE) begin
                len_q <= LEN_W'(1);
                cmd_q <= {bus.MOSI, 1'b0};
            end else if (in_frame && len_q != '1) begin
                len_q <= len_q + 1'b1;
            end
            unique case (state_q)
                CMD: begin
                    cmd_q[0] <= bus.MOSI;
                    cnt_q    <= '0;
                end
                PAYLOAD: begin
                    data_sr <= {data_sr[DATA_W-2:0], bus.MOSI};
                    cnt_q   <= (cnt_q == BIT_LAST) ? '0 : cnt_q + 1'b1;
                end
                GAP:   cnt_q <= (cnt_q == GAP_LAST) ? '0 : cnt_q + 1'b1;
                RDATA: begin
                    rd_sr <= {rd_sr[DATA_W-2:0], bus.MISO};
                    cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Registered result and error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            rd_valid    <= 1'b0;
            err_len     <= 1'b0;
            err_order   <= 1'b0;
            err_miso    <= 1'b0;
            frame_cmd   <= 2'b00;
            frame_data  <= '0;
            rd_data     <= '0;
            rd_pending  <= 1'b0;
            err_count   <= '0;
        end else begin
            frame_valid <= good;
            rd_valid    <= good && is_rd;
            err_len     <= frame_end && !len_ok;
            err_order   <= good && is_rd && !rd_pending;
            err_miso    <= bus.MISO && (state_q != RDATA);
            if (good) begin
                frame_cmd  <= cmd_q;
                frame_data <= data_sr;
                if (is_rd)              rd_pending <= 1'b0;
                else if (cmd_q == 2'b10) rd_pending <= 1'b1;
            end
            if (good && is_rd) rd_data <= rd_sr;
            if (any_err && err_count != '1) err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_protocol_monitor.sv
// Directed bench for spi_protocol_monitor (DATA_W=8, READ_LAT=1).
// A second instance with CNT_W=2 shares the bus to check counter saturation.
module tb_spi_protocol_monitor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    spi_protocol_monitor_if bus ();

    logic       frame_valid, rd_valid, err_len, err_order, err_miso;
    logic [1:0] frame_cmd;
    logic [7:0] frame_data, rd_data, err_count;

    logic       fv2, rv2, el2, eo2, em2;
    logic [1:0] fc2;
    logic [7:0] fd2, rd2;
    logic [1:0] ec2;

    spi_protocol_monitor #(.DATA_W(8), .READ_LAT(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .frame_valid(frame_valid), .frame_cmd(frame_cmd),
        .frame_data(frame_data), .rd_valid(rd_valid), .rd_data(rd_data),
        .err_len(err_len), .err_order(err_order), .err_miso(err_miso),
        .err_count(err_count)
    );

    spi_protocol_monitor #(.DATA_W(8), .READ_LAT(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .frame_valid(fv2), .frame_cmd(fc2), .frame_data(fd2),
        .rd_valid(rv2), .rd_data(rd2), .err_len(el2), .err_order(eo2),
        .err_miso(em2), .err_count(ec2)
    );

    int pass_n = 0;
    int tot_n = 0;

    int fv_n = 0, rv_n = 0, el_n = 0, eo_n = 0, em_n = 0;

    always @(posedge clk) begin
        #1;
        if (frame_valid) fv_n++;
        if (rd_valid)    rv_n++;
        if (err_len)     el_n++;
        if (err_order)   eo_n++;
        if (err_miso)    em_n++;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        bus.MISO = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Drives len SS_n-low samples, then SS_n high; with settle the task
    // returns on the edge where frame-end outputs are visible.
    task automatic frame(input logic [1:0] cmd, input logic [7:0] d,
                         input int len, input logic [7:0] rw,
                         input logic gm, input bit settle);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            bus.SS_n = 1'b0;
            if (i == 0)      bus.MOSI = cmd[1];
            else if (i == 1) bus.MOSI = cmd[0];
            else if (i < 10) bus.MOSI = d[9-i];
            else             bus.MOSI = 1'b0;
            if (i == 10)                bus.MISO = gm;
            else if (i >= 11 && i < 19) bus.MISO = rw[18-i];
            else                        bus.MISO = 1'b0;
        end
        @(negedge clk);
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        bus.MISO = 1'b0;
        if (settle) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        tot_n++;
        if ({frame_valid, rd_valid, err_len, err_order, err_miso} !== 5'b0)
            $display("FAIL reset_pulses: got %b want 00000",
                     {frame_valid, rd_valid, err_len, err_order, err_miso});
        else pass_n++;
        tot_n++;
        if ({frame_cmd, frame_data, rd_data, err_count} !== 26'h0)
            $display("FAIL reset_regs: got %h want 0",
                     {frame_cmd, frame_data, rd_data, err_count});
        else pass_n++;
    endtask

    task automatic test_write();
        frame(2'b00, 8'hA5, 10, 8'h00, 1'b0, 1'b1);
        tot_n++;
        if ({frame_valid, err_len, frame_cmd, frame_data} !== {1'b1, 1'b0, 2'b00, 8'hA5})
            $display("FAIL write_frame: got v=%b el=%b cmd=%b d=%h want 1 0 00 a5",
                     frame_valid, err_len, frame_cmd, frame_data);
        else pass_n++;
        @(negedge clk);
        tot_n++;
        if ({frame_valid, err_count} !== {1'b0, 8'd0})
            $display("FAIL write_after: got v=%b ec=%0d want 0 0",
                     frame_valid, err_count);
        else pass_n++;
    endtask

    task automatic test_read();
        int em0 = em_n;
        frame(2'b10, 8'h3C, 10, 8'h00, 1'b0, 1'b1);
        tot_n++;
        if ({frame_valid, frame_cmd, frame_data} !== {1'b1, 2'b10, 8'h3C})
            $display("FAIL rd_addr: got v=%b cmd=%b d=%h want 1 10 3c",
                     frame_valid, frame_cmd, frame_data);
        else pass_n++;
        frame(2'b11, 8'h00, 19, 8'h5A, 1'b0, 1'b1);
        tot_n++;
        if ({frame_valid, rd_valid, err_order, rd_data, frame_cmd} !==
            {1'b1, 1'b1, 1'b0, 8'h5A, 2'b11})
            $display("FAIL rd_data: got v=%b rv=%b eo=%b rd=%h cmd=%b want 1 1 0 5a 11",
                     frame_valid, rd_valid, err_order, rd_data, frame_cmd);
        else pass_n++;
        tot_n++;
        if (em_n - em0 !== 0)
            $display("FAIL rd_miso_quiet: got %0d err_miso want 0", em_n - em0);
        else pass_n++;
    endtask

    task automatic test_order();
        do_reset();
        frame(2'b11, 8'hC3, 19, 8'h81, 1'b0, 1'b1);
        tot_n++;
        if ({err_order, rd_valid, frame_valid, rd_data} !== {3'b111, 8'h81})
            $display("FAIL order_err: got eo=%b rv=%b v=%b rd=%h want 1 1 1 81",
                     err_order, rd_valid, frame_valid, rd_data);
        else pass_n++;
        @(negedge clk);
        tot_n++;
        if ({err_count, ec2} !== {8'd1, 2'd1})
            $display("FAIL order_count: got %0d/%0d want 1/1", err_count, ec2);
        else pass_n++;
    endtask

    task automatic test_len();
        int fv0 = fv_n;
        int el0 = el_n;
        frame(2'b01, 8'h77, 7, 8'h00, 1'b0, 1'b1);
        tot_n++;
        if ({err_len, frame_valid, frame_data} !== {2'b10, 8'hC3})
            $display("FAIL len_short: got el=%b v=%b d=%h want 1 0 c3",
                     err_len, frame_valid, frame_data);
        else pass_n++;
        frame(2'b00, 8'h11, 11, 8'h00, 1'b0, 1'b1);
        frame(2'b00, 8'h11, 74, 8'h00, 1'b0, 1'b1);
        frame(2'b00, 8'h11, 300, 8'h00, 1'b0, 1'b1);
        tot_n++;
        if ({err_len, frame_valid} !== 2'b10)
            $display("FAIL len_300: got el=%b v=%b want 1 0", err_len, frame_valid);
        else pass_n++;
        tot_n++;
        if ({el_n - el0, fv_n - fv0} !== {32'd4, 32'd0})
            $display("FAIL len_totals: got el=%0d v=%0d want 4 0",
                     el_n - el0, fv_n - fv0);
        else pass_n++;
    endtask

    task automatic test_miso();
        int em0;
        do_reset();
        em0 = em_n;
        bus.MISO = 1'b1;
        repeat (3) @(negedge clk);
        bus.MISO = 1'b0;
        @(negedge clk);
        frame(2'b10, 8'h01, 10, 8'h00, 1'b0, 1'b1);
        frame(2'b11, 8'h00, 19, 8'hFF, 1'b1, 1'b1);
        @(negedge clk);
        tot_n++;
        if (em_n - em0 !== 4)
            $display("FAIL miso_pulses: got %0d want 4", em_n - em0);
        else pass_n++;
        tot_n++;
        if ({err_count, rd_data} !== {8'd4, 8'hFF})
            $display("FAIL miso_count: got ec=%0d rd=%h want 4 ff",
                     err_count, rd_data);
        else pass_n++;
    endtask

    task automatic test_back_to_back();
        int fv0 = fv_n;
        int el0 = el_n;
        frame(2'b00, 8'h12, 10, 8'h00, 1'b0, 1'b0);
        frame(2'b01, 8'h34, 10, 8'h00, 1'b0, 1'b0);
        frame(2'b10, 8'h56, 10, 8'h00, 1'b0, 1'b1);
        tot_n++;
        if ({fv_n - fv0, el_n - el0} !== {32'd3, 32'd0})
            $display("FAIL b2b_counts: got v=%0d el=%0d want 3 0",
                     fv_n - fv0, el_n - el0);
        else pass_n++;
        tot_n++;
        if ({frame_cmd, frame_data} !== {2'b10, 8'h56})
            $display("FAIL b2b_last: got cmd=%b d=%h want 10 56",
                     frame_cmd, frame_data);
        else pass_n++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d = 8'h3C;
        int n0 = fv_n + el_n + eo_n + rv_n;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.SS_n = 1'b0;
            bus.MOSI = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : d[9-i];
        end
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.MOSI = 1'b1;
        repeat (5) @(negedge clk);
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        repeat (2) @(negedge clk);
        tot_n++;
        if (fv_n + el_n + eo_n + rv_n - n0 !== 0)
            $display("FAIL mid_quiet: got %0d pulses want 0",
                     fv_n + el_n + eo_n + rv_n - n0);
        else pass_n++;
        tot_n++;
        if ({frame_data, rd_data, err_count} !== 24'h0)
            $display("FAIL mid_regs: got %h want 0",
                     {frame_data, rd_data, err_count});
        else pass_n++;
        frame(2'b11, 8'h24, 19, 8'h99, 1'b0, 1'b1);
        tot_n++;
        if ({err_order, rd_valid, rd_data} !== {2'b11, 8'h99})
            $display("FAIL mid_order: got eo=%b rv=%b rd=%h want 1 1 99",
                     err_order, rd_valid, rd_data);
        else pass_n++;
    endtask

    task automatic test_sat();
        repeat (4) frame(2'b00, 8'h00, 3, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        tot_n++;
        if ({err_count, ec2} !== {8'd5, 2'd3})
            $display("FAIL sat_count: got %0d/%0d want 5/3", err_count, ec2);
        else pass_n++;
    endtask

    initial begin
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        bus.MISO = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_order();
        test_len();
        test_miso();
        test_back_to_back();
        test_reset_mid();
        test_sat();
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end

endmodule
